// File: rtl/ex_mem_pkg.sv
// Shared CPU defines for the EX/MEM pipeline register: bus widths, stall-bit
// indices, reset level and the per-edge action decode.
package ex_mem_pkg;

  localparam int unsigned REG_BUS        = 32;
  localparam int unsigned REG_ADDR_BUS   = 5;
  localparam int unsigned DOUBLE_REG_BUS = 64;
  localparam int unsigned STALL_BUS      = 6;

  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;

  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = '0;
  localparam logic [REG_BUS-1:0]      ZERO_WORD    = '0;
  localparam logic                    RST_ENABLE   = 1'b0;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_FLUSH
  } ex_mem_action_e;

  // Flush beats everything; EX stalled with MEM running inserts a bubble;
  // EX running always advances, even with the illegal MEM-only stall.
  function automatic ex_mem_action_e decode_action(input logic flush,
                                                   input logic [STALL_BUS-1:0] stall);
    if (flush)                                  return ACT_FLUSH;
    else if (stall[STALL_EX] && !stall[STALL_MEM]) return ACT_BUBBLE;
    else if (!stall[STALL_EX])                  return ACT_ADVANCE;
    else                                        return ACT_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush, bubble insertion and hold, plus the
// multi-cycle accumulate state (hilo/cnt) looped back to EX during bubbles.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_BUS-1:0]      stall,
  input  logic                      flush,
  input  logic [REG_ADDR_BUS-1:0]   ex_wd,
  input  logic                      ex_wreg,
  input  logic [REG_BUS-1:0]        ex_wdata,
  input  logic                      ex_whilo,
  input  logic [REG_BUS-1:0]        ex_hi,
  input  logic [REG_BUS-1:0]        ex_lo,
  input  logic [DOUBLE_REG_BUS-1:0] hilo_i,
  input  logic [1:0]                cnt_i,
  output logic [REG_ADDR_BUS-1:0]   mem_wd,
  output logic                      mem_wreg,
  output logic [REG_BUS-1:0]        mem_wdata,
  output logic                      mem_whilo,
  output logic [REG_BUS-1:0]        mem_hi,
  output logic [REG_BUS-1:0]        mem_lo,
  output logic [DOUBLE_REG_BUS-1:0] hilo_o,
  output logic [1:0]                cnt_o,
  output logic                      mem_valid
);

  ex_mem_action_e action;

  always_comb begin
    action = decode_action(flush, stall);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      mem_wd    <= NOP_REG_ADDR;
      mem_wreg  <= 1'b0;
      mem_wdata <= ZERO_WORD;
      mem_whilo <= 1'b0;
      mem_hi    <= ZERO_WORD;
      mem_lo    <= ZERO_WORD;
      hilo_o    <= '0;
      cnt_o     <= '0;
      mem_valid <= 1'b0;
    end else begin
      unique case (action)
        ACT_FLUSH: begin
          mem_wd    <= NOP_REG_ADDR;
          mem_wreg  <= 1'b0;
          mem_wdata <= ZERO_WORD;
          mem_whilo <= 1'b0;
          mem_hi    <= ZERO_WORD;
          mem_lo    <= ZERO_WORD;
          hilo_o    <= '0;
          cnt_o     <= '0;
          mem_valid <= 1'b0;
        end
        ACT_BUBBLE: begin
          // MEM sees a NOP while EX's in-flight accumulate is parked here
          mem_wd    <= NOP_REG_ADDR;
          mem_wreg  <= 1'b0;
          mem_wdata <= ZERO_WORD;
          mem_whilo <= 1'b0;
          mem_hi    <= ZERO_WORD;
          mem_lo    <= ZERO_WORD;
          hilo_o    <= hilo_i;
          cnt_o     <= cnt_i;
          mem_valid <= 1'b0;
        end
        ACT_ADVANCE: begin
          mem_wd    <= ex_wd;
          mem_wreg  <= ex_wreg;
          mem_wdata <= ex_wdata;
          mem_whilo <= ex_whilo;
          mem_hi    <= ex_hi;
          mem_lo    <= ex_lo;
          hilo_o    <= '0;
          cnt_o     <= '0;
          mem_valid <= 1'b1;
        end
        default: begin
          mem_wd    <= mem_wd;
          mem_wreg  <= mem_wreg;
          mem_wdata <= mem_wdata;
          mem_whilo <= mem_whilo;
          mem_hi    <= mem_hi;
          mem_lo    <= mem_lo;
          hilo_o    <= hilo_o;
          cnt_o     <= cnt_o;
          mem_valid <= mem_valid;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: directed vectors push hand-computed expected
// outputs; a monitor pops and compares at each negedge or on demand.
module tb_ex_mem;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
  logic        mem_valid;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .hilo_o(hilo_o), .cnt_o(cnt_o), .mem_valid(mem_valid)
  );

  typedef struct {
    string       name;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  event sample_now;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string name, input logic [4:0] wd, input logic wreg,
                      input logic [31:0] wdata, input logic whilo,
                      input logic [31:0] hi, input logic [31:0] lo,
                      input logic [63:0] hilo, input logic [1:0] cnt,
                      input logic valid);
    exp_t e;
    e.name = name; e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.whilo = whilo;
    e.hi = hi; e.lo = lo; e.hilo = hilo; e.cnt = cnt; e.valid = valid;
    exp_q.push_back(e);
  endtask

  task automatic push_zero(input string name);
    push(name, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 1'b0);
  endtask

  // Inputs are already driven; let one edge capture them, then queue the expectation.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_whilo = whilo; ex_hi = hi; ex_lo = lo;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or sample_now);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        if (mem_wd !== e.wd || mem_wreg !== e.wreg || mem_wdata !== e.wdata ||
            mem_whilo !== e.whilo || mem_hi !== e.hi || mem_lo !== e.lo ||
            hilo_o !== e.hilo || cnt_o !== e.cnt || mem_valid !== e.valid) begin
          mismatched++;
          $display("FAIL %s: got wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h hilo=%h cnt=%0d valid=%b; want wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h hilo=%h cnt=%0d valid=%b",
                   e.name, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o, mem_valid,
                   e.wd, e.wreg, e.wdata, e.whilo, e.hi, e.lo, e.hilo, e.cnt, e.valid);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b0; stall = 6'b0; flush = 1'b0;
    drive_ex(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    hilo_i = 64'h0; cnt_i = 2'd0;
    #1;
    push_zero("reset_state");
    -> sample_now;
    @(negedge clk); #1;
    rst = 1'b1;

    // Plain advance, then an advance with no GPR write (store-like)
    drive_ex(5'd5, 1'b1, 32'h12345678, 1'b1, 32'hA1A1A1A1, 32'hB2B2B2B2);
    tick(); push("advance", 5'd5, 1'b1, 32'h12345678, 1'b1, 32'hA1A1A1A1, 32'hB2B2B2B2, 64'h0, 2'd0, 1'b1);
    drive_ex(5'd0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0);
    tick(); push("advance_nowreg", 5'd0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 1'b1);

    // Consecutive bubbles track the progressing count, then hold freezes it
    drive_ex(5'd7, 1'b1, 32'h0BADF00D, 1'b1, 32'h1, 32'h2);
    stall = 6'b001111; hilo_i = 64'h00000001_00000002; cnt_i = 2'd1;
    tick(); push("bubble1", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h00000001_00000002, 2'd1, 1'b0);
    hilo_i = 64'h00000003_00000004; cnt_i = 2'd2;
    tick(); push("bubble2", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h00000003_00000004, 2'd2, 1'b0);
    stall = 6'b011111; hilo_i = 64'hFFFFFFFF_FFFFFFFF; cnt_i = 2'd3;
    tick(); push("bubble_hold", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h00000003_00000004, 2'd2, 1'b0);
    stall = 6'b000000;
    drive_ex(5'd7, 1'b1, 32'h00000011, 1'b0, 32'h0, 32'h0);
    tick(); push("advance_after_bubble", 5'd7, 1'b1, 32'h00000011, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 1'b1);

    // MEM-only stall is treated as advance
    stall = 6'b010000;
    drive_ex(5'd9, 1'b1, 32'h00000022, 1'b0, 32'h0, 32'h0);
    tick(); push("illegal_stall_adv", 5'd9, 1'b1, 32'h00000022, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 1'b1);

    // Hold for three cycles
    stall = 6'b000000;
    drive_ex(5'd3, 1'b1, 32'hAAAA5555, 1'b1, 32'h33333333, 32'h44444444);
    tick(); push("load_hold", 5'd3, 1'b1, 32'hAAAA5555, 1'b1, 32'h33333333, 32'h44444444, 64'h0, 2'd0, 1'b1);
    stall = 6'b011111;
    drive_ex(5'd31, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      tick(); push($sformatf("hold%0d", i), 5'd3, 1'b1, 32'hAAAA5555, 1'b1, 32'h33333333, 32'h44444444, 64'h0, 2'd0, 1'b1);
    end

    // Flush beats hold, bubble and advance
    flush = 1'b1;
    tick(); push_zero("flush_over_hold");
    flush = 1'b0; stall = 6'b001111; hilo_i = 64'h00000005_00000006; cnt_i = 2'd1;
    tick(); push("bubble_pre_flush", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h00000005_00000006, 2'd1, 1'b0);
    flush = 1'b1; cnt_i = 2'd2;
    tick(); push_zero("flush_over_bubble");
    stall = 6'b000000;
    drive_ex(5'd4, 1'b1, 32'h00000044, 1'b1, 32'h1, 32'h1);
    tick(); push_zero("flush_over_advance");
    flush = 1'b0;

    // Asynchronous reset with valid data held, then release
    drive_ex(5'd1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
    tick(); push("load_deadbeef", 5'd1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 1'b1);
    @(negedge clk); #1;
    rst = 1'b0; #1;
    push_zero("async_reset_data");
    -> sample_now;
    #1;
    rst = 1'b1;
    drive_ex(5'd1, 1'b1, 32'h00000001, 1'b0, 32'h0, 32'h0);
    tick(); push("post_reset_adv", 5'd1, 1'b1, 32'h00000001, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 1'b1);

    // Reset mid multi-cycle operation drops the partial result
    stall = 6'b001111; hilo_i = 64'h00000007_00000008; cnt_i = 2'd1;
    tick(); push("bubble_pre_reset", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h00000007_00000008, 2'd1, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0; #1;
    push_zero("async_reset_cnt");
    -> sample_now;
    @(posedge clk); #1;
    push_zero("reset_held_over_edge");
    #1;
    rst = 1'b1; stall = 6'b000000;
    drive_ex(5'd2, 1'b1, 32'h00000002, 1'b0, 32'h0, 32'h0);
    tick(); push("post_reset_adv2", 5'd2, 1'b1, 32'h00000002, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, 1'b1);

    @(negedge clk); #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
